muldiv_seq: RTL

Iterative RV32M multiply/divide sequencer sitting beside the single-cycle ALU in the EX stage. It decodes R-type instructions with funct7 = 0000001, runs a shift-add multiply or restoring divide over XLEN cycles, and holds the pipeline with a stall until the result is ready. Non-M instructions pass untouched; the ALU control path keeps handling them.

---
 rtl/muldiv_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
//   Decodes R-type instructions with funct7=0000001, runs an XLEN-cycle
//   shift-add multiply or restoring divide, and stalls the pipeline until the
//   result is ready. Divide-by-zero and signed overflow finish in one cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid          EX stage holds a valid instruction
//   opcode/funct3/funct7  instruction decode fields
//   rs1_data/rs2_data operands A and B, sampled only at accept
//   flush             squash the in-flight operation (also blocks accept)
//   stall             hold IF/ID/EX (combinational)
//   out_valid         one-cycle pulse, result valid
//   result            registered result, held until overwritten
//   busy              sequencer not idle
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic            neg_q;    // negate product / quotient
  logic            rneg_q;   // negate remainder
  logic [XLEN-1:0] opnd_q;   // multiplicand (MUL) or divisor (DIV) magnitude
  logic [XLEN-1:0] hi_q;     // accumulator (MUL) or partial remainder (DIV)
  logic [XLEN-1:0] lo_q;     // multiplier (MUL) or dividend->quotient (DIV)
  logic [CW-1:0]   cnt_q;

  // ---------------- decode / accept ----------------
  logic            is_m, accept, last;
  logic            a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div0, ovf, special;
  logic [XLEN-1:0] special_res;

  assign is_m   = in_valid && opcode == 7'b0110011 && funct7 == 7'b0000001;
  assign accept = state_q == S_IDLE && is_m && !flush;
  assign last   = cnt_q == LAST;

  // MULH, MULHSU, DIV, REM sign-extend A; MULH, DIV, REM sign-extend B.
  // MUL is treated as unsigned: its low half does not depend on signedness.
  assign a_sgn = funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
  assign b_sgn = funct3 inside {3'd1, 3'd4, 3'd6};
  assign sa    = a_sgn & rs1_data[XLEN-1];
  assign sb    = b_sgn & rs2_data[XLEN-1];
  assign abs_a = sa ? -rs1_data : rs1_data;
  assign abs_b = sb ? -rs2_data : rs2_data;

  // Division corner cases bypass the iteration entirely.
  assign div0    = rs2_data == '0;
  assign ovf     = !funct3[0] && rs1_data == {1'b1, {(XLEN-1){1'b0}}} && &rs2_data;
  assign special = funct3[2] && (div0 || ovf);
  // funct3[1] separates REM/REMU from DIV/DIVU.
  assign special_res = div0 ? (funct3[1] ? rs1_data : '1)
                            : (funct3[1] ? '0 : rs1_data);

  // ---------------- one multiply step ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res;

  assign mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
  // {carry,acc,multiplier} >> 1: carry enters acc MSB, acc LSB enters multiplier
  assign mul_hi_n = mul_sum[XLEN:1];
  assign mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
  assign prod     = {mul_hi_n, mul_lo_n};
  assign prod_s   = neg_q ? -prod : prod;
  assign mul_res  = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

  // ---------------- one divide step ----------------
  logic [XLEN:0]   div_shl;
  logic            div_ge;
  logic [XLEN-1:0] div_diff, div_hi_n, div_lo_n, quo_s, rem_s, div_res;

  assign div_shl  = {hi_q, lo_q[XLEN-1]};
  assign div_ge   = div_shl >= {1'b0, opnd_q};
  // When div_ge holds the difference is below the divisor, so it fits XLEN bits.
  assign div_diff = XLEN'(div_shl - {1'b0, opnd_q});
  assign div_hi_n = div_ge ? div_diff : div_shl[XLEN-1:0];
  assign div_lo_n = {lo_q[XLEN-2:0], div_ge};
  assign quo_s    = neg_q  ? -div_lo_n : div_lo_n;
  assign rem_s    = rneg_q ? -div_hi_n : div_hi_n;
  assign div_res  = op_q[1] ? rem_s : quo_s;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (accept) state_d = special ? S_DONE : (funct3[2] ? S_DIV : S_MUL);
      S_MUL, S_DIV: if (last) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  // stall drops in DONE so the core advances past the M instruction.
  always_comb begin
    stall     = is_m && state_q != S_DONE;
    busy      = state_q != S_IDLE;
    out_valid = state_q == S_DONE && !flush;
  end

  // ---------------- datapath ----------------
  // The final iteration writes result directly so it is valid in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      result <= '0;
    end else if (accept) begin
      op_q   <= funct3;
      neg_q  <= sa ^ sb;
      rneg_q <= sa;
      hi_q   <= '0;
      cnt_q  <= '0;
      opnd_q <= funct3[2] ? abs_b : abs_a;
      lo_q   <= funct3[2] ? abs_a : abs_b;
      if (special) result <= special_res;
    end else if (!flush) begin
      if (state_q == S_MUL) begin
        hi_q  <= mul_hi_n;
        lo_q  <= mul_lo_n;
        cnt_q <= cnt_q + 1'b1;
        if (last) result <= mul_res;
      end else if (state_q == S_DIV) begin
        hi_q  <= div_hi_n;
        lo_q  <= div_lo_n;
        cnt_q <= cnt_q + 1'b1;
        if (last) result <= div_res;
      end
    end
  end

endmodule
